// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, trap causes,
// instruction op encodings and mstatus layout.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MCAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] MCAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] MCAUSE_ECALL_M    = 32'd11;

  localparam logic [1:0] OP_RW  = 2'b00;
  localparam logic [1:0] OP_RS  = 2'b01;
  localparam logic [1:0] OP_RC  = 2'b10;
  localparam logic [1:0] F3_RW  = 2'b01;
  localparam logic [1:0] F3_RS  = 2'b10;
  localparam logic [1:0] F3_RC  = 2'b11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_action_e;

  // MPP is hardwired to machine mode; only MIE and MPIE hold state.
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = 32'd0;
    v[MSTATUS_MIE]                       = mie;
    v[MSTATUS_MPIE]                      = mpie;
    v[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO]   = 2'b11;
    return v;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half write ports.
// A half write replaces the increment for that cycle; the other half is kept.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_count
);

  logic [63:0] r_count;

  // Counter state: half writes take priority over the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 64'd0;
    end else if (i_wr_lo) begin
      r_count[31:0] <= i_wdata;
    end else if (i_wr_hi) begin
      r_count[63:32] <= i_wdata;
    end else if (i_inc) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file for the single-cycle RV32I core: CSR read/modify/write,
// cycle/instret counters, trap entry and MRET return targets.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] i_csr_addr,
  input  logic        i_csr_write_enable,
  input  logic [1:0]  i_csr_op,
  input  logic [4:0]  i_csr_imm,
  input  logic [2:0]  i_csr_funct3,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_pc,
  input  logic        i_instr_retire,
  input  logic        i_trap_ecall,
  input  logic        i_trap_ebreak,
  input  logic        i_trap_illegal,
  input  logic        i_mret,
  output logic [31:0] o_csr_rdata,
  output logic        o_csr_illegal,
  output logic        o_trap_taken,
  output logic [31:0] o_trap_target,
  output logic [31:0] o_mret_target
);

  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic        r_mie, r_mpie;
  logic [63:0] w_mcycle, w_minstret;
  logic [31:0] w_operand, w_old, w_wdata, w_cause;
  csr_action_e w_action;
  logic        w_write_type, w_mapped, w_readonly, w_illegal, w_trap, w_wen;

  assign w_operand = i_csr_funct3[2] ? {27'd0, i_csr_imm} : i_rs1_data;

  // Decode the requested read-modify-write action
  always_comb begin
    w_action = CSR_NONE;
    case (i_csr_op)
      OP_RW:   w_action = CSR_WRITE;
      OP_RS:   w_action = CSR_SET;
      OP_RC:   w_action = CSR_CLEAR;
      default: begin
        case (i_csr_funct3[1:0])
          F3_RW:   w_action = CSR_WRITE;
          F3_RS:   w_action = CSR_SET;
          F3_RC:   w_action = CSR_CLEAR;
          default: w_action = CSR_NONE;
        endcase
      end
    endcase
  end

  assign w_write_type = (w_action == CSR_WRITE) ||
                        (((w_action == CSR_SET) || (w_action == CSR_CLEAR)) &&
                         (w_operand != 32'd0));

  // Read mux: pre-write value of the addressed CSR, zero when unmapped
  always_comb begin
    w_old    = 32'd0;
    w_mapped = 1'b1;
    case (i_csr_addr)
      CSR_MSTATUS:               w_old = mstatus_pack(r_mie, r_mpie);
      CSR_MISA:                  w_old = MISA_VALUE;
      CSR_MHARTID:               w_old = HART_ID;
      CSR_MTVEC:                 w_old = r_mtvec;
      CSR_MSCRATCH:              w_old = r_mscratch;
      CSR_MEPC:                  w_old = r_mepc;
      CSR_MCAUSE:                w_old = r_mcause;
      CSR_MCYCLE,    CSR_CYCLE:    w_old = w_mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   w_old = w_mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  w_old = w_minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_old = w_minstret[63:32];
      default:                   w_mapped = 1'b0;
    endcase
  end

  assign w_readonly = (i_csr_addr[11:10] == 2'b11) || (i_csr_addr == CSR_MISA) ||
                      (i_csr_addr == CSR_MHARTID);
  assign w_illegal  = i_csr_write_enable && (!w_mapped || (w_write_type && w_readonly));
  assign w_trap     = i_trap_ecall || i_trap_ebreak || i_trap_illegal || w_illegal;
  assign w_wen      = i_csr_write_enable && w_write_type && w_mapped && !w_readonly && !w_trap;

  // New value for the addressed CSR
  always_comb begin
    case (w_action)
      CSR_WRITE: w_wdata = w_operand;
      CSR_SET:   w_wdata = w_old | w_operand;
      CSR_CLEAR: w_wdata = w_old & ~w_operand;
      default:   w_wdata = w_old;
    endcase
  end

  // Trap cause priority: illegal, then breakpoint, then ecall
  always_comb begin
    if (i_trap_illegal || w_illegal) begin
      w_cause = MCAUSE_ILLEGAL;
    end else if (i_trap_ebreak) begin
      w_cause = MCAUSE_BREAKPOINT;
    end else begin
      w_cause = MCAUSE_ECALL_M;
    end
  end

  // Trap/MRET state and CSR writes; a trap suppresses the write and beats MRET
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtvec    <= MTVEC_RESET;
      r_mscratch <= 32'd0;
      r_mepc     <= 32'd0;
      r_mcause   <= 32'd0;
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
    end else if (w_trap) begin
      r_mepc   <= i_pc;
      r_mcause <= w_cause;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else begin
      if (w_wen) begin
        case (i_csr_addr)
          CSR_MSTATUS: begin
            r_mie  <= w_wdata[MSTATUS_MIE];
            r_mpie <= w_wdata[MSTATUS_MPIE];
          end
          CSR_MTVEC:    r_mtvec    <= {w_wdata[31:2], 2'b00};
          CSR_MSCRATCH: r_mscratch <= w_wdata;
          CSR_MEPC:     r_mepc     <= {w_wdata[31:2], 2'b00};
          CSR_MCAUSE:   r_mcause   <= w_wdata;
          default:      ;
        endcase
      end
      if (i_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (1'b1),
    .i_wr_lo (w_wen && (i_csr_addr == CSR_MCYCLE)),
    .i_wr_hi (w_wen && (i_csr_addr == CSR_MCYCLEH)),
    .i_wdata (w_wdata),
    .o_count (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (i_instr_retire && !w_trap),
    .i_wr_lo (w_wen && (i_csr_addr == CSR_MINSTRET)),
    .i_wr_hi (w_wen && (i_csr_addr == CSR_MINSTRETH)),
    .i_wdata (w_wdata),
    .o_count (w_minstret)
  );

  assign o_csr_rdata   = w_old;
  assign o_csr_illegal = w_illegal;
  assign o_trap_taken  = w_trap;
  assign o_trap_target = {r_mtvec[31:2], 2'b00};
  assign o_mret_target = r_mepc;

endmodule

// File: tb/tb_csr_unit.sv
// Randomized and directed bench for csr_unit against a behavioural CSR model.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [1:0]  csr_op;
  logic [4:0]  csr_imm;
  logic [2:0]  csr_funct3;
  logic [31:0] rs1_data, pc;
  logic        retire, ecall, ebreak, illegal_in, mret;
  logic [31:0] rdata, trap_target, mret_target;
  logic        csr_illegal, trap_taken;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_scratch, m_tvec, m_epc, m_cause;
  logic        m_mie, m_mpie;
  logic [63:0] m_cyc, m_ret;

  logic [11:0] addr_tab [18] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                 12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h000, 12'h344};

  always #5 clk = ~clk;

  csr_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_csr_addr         (csr_addr),
    .i_csr_write_enable (csr_we),
    .i_csr_op           (csr_op),
    .i_csr_imm          (csr_imm),
    .i_csr_funct3       (csr_funct3),
    .i_rs1_data         (rs1_data),
    .i_pc               (pc),
    .i_instr_retire     (retire),
    .i_trap_ecall       (ecall),
    .i_trap_ebreak      (ebreak),
    .i_trap_illegal     (illegal_in),
    .i_mret             (mret),
    .o_csr_rdata        (rdata),
    .o_csr_illegal      (csr_illegal),
    .o_trap_taken       (trap_taken),
    .o_trap_target      (trap_target),
    .o_mret_target      (mret_target)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_scratch = 32'd0; m_tvec = 32'd0; m_epc = 32'd0; m_cause = 32'd0;
    m_mie = 1'b0; m_mpie = 1'b0; m_cyc = 64'd0; m_ret = 64'd0;
  endtask

  // Returns 1 when the address names an implemented CSR.
  function automatic logic model_read(input logic [11:0] a, output logic [31:0] v);
    logic known;
    known = 1'b1;
    v = 32'd0;
    case (a)
      12'h300: v = {19'd0, 2'b11, 3'd0, m_mpie, 3'd0, m_mie, 3'd0};
      12'h301: v = 32'h4000_0100;
      12'hF14: v = 32'd0;
      12'h305: v = m_tvec;
      12'h340: v = m_scratch;
      12'h341: v = m_epc;
      12'h342: v = m_cause;
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ret[31:0];
      12'hB82, 12'hC82: v = m_ret[63:32];
      default: known = 1'b0;
    endcase
    return known;
  endfunction

  // Check this cycle's combinational outputs, then advance the model over the edge.
  task automatic run_cycle();
    logic [31:0] old, opnd, nv;
    logic [63:0] cyc_n, ret_n;
    logic        known, wr, ill, trap, t;
    int          kind;
    #1;
    known = model_read(csr_addr, old);
    opnd  = csr_funct3[2] ? {27'd0, csr_imm} : rs1_data;
    kind  = (csr_op == 2'b11) ? int'(csr_funct3[1:0]) : int'(csr_op) + 1;
    wr    = (kind == 1) || (kind >= 2 && opnd != 32'd0);
    ill   = csr_we && (!known || (wr && (csr_addr[11:10] == 2'b11 || csr_addr == 12'h301)));
    trap  = ecall || ebreak || illegal_in || ill;
    check("rdata", rdata, old);
    check("csr_illegal", {31'd0, csr_illegal}, {31'd0, ill});
    check("trap_taken", {31'd0, trap_taken}, {31'd0, trap});
    check("trap_target", trap_target, m_tvec & ~32'd3);
    check("mret_target", mret_target, m_epc);
    nv = (kind == 1) ? opnd : (kind == 2) ? (old | opnd) : (old & ~opnd);
    @(posedge clk);
    cyc_n = m_cyc + 64'd1;
    ret_n = (retire && !trap) ? m_ret + 64'd1 : m_ret;
    if (csr_we && wr && known && !trap) begin
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_tvec = nv & ~32'd3;
        12'h340: m_scratch = nv;
        12'h341: m_epc = nv & ~32'd3;
        12'h342: m_cause = nv;
        12'hB00: cyc_n = {m_cyc[63:32], nv};
        12'hB80: cyc_n = {nv, m_cyc[31:0]};
        12'hB02: ret_n = {m_ret[63:32], nv};
        12'hB82: ret_n = {nv, m_ret[31:0]};
        default: ;
      endcase
    end
    if (trap) begin
      m_epc   = pc;
      m_cause = (illegal_in || ill) ? 32'd2 : ebreak ? 32'd3 : 32'd11;
      m_mpie  = m_mie;
      m_mie   = 1'b0;
    end else if (mret) begin
      t = m_mpie;
      m_mpie = 1'b1;
      m_mie  = t;
    end
    m_cyc = cyc_n;
    m_ret = ret_n;
    @(negedge clk);
  endtask

  task automatic set_idle();
    csr_addr = 12'h000; csr_we = 1'b0; csr_op = 2'b00; csr_imm = 5'd0; csr_funct3 = 3'd0;
    rs1_data = 32'd0; pc = 32'd0; retire = 1'b0; ecall = 1'b0; ebreak = 1'b0;
    illegal_in = 1'b0; mret = 1'b0;
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [1:0] op, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [4:0] imm);
    set_idle();
    csr_addr = a; csr_we = 1'b1; csr_op = op; csr_funct3 = f3;
    rs1_data = rs1; csr_imm = imm; retire = 1'b1;
  endtask

  task automatic set_read(input logic [11:0] a);
    set_idle();
    csr_addr = a;
  endtask

  task automatic reset_check();
    rst_n = 1'b0;
    model_reset();
    set_read(12'h300);
    #2;
    check("rst_mstatus", rdata, 32'h0000_1800);
    check("rst_trap_target", trap_target, 32'd0);
    check("rst_mret_target", mret_target, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    set_idle();
    reset_check();
    for (int i = 0; i < 5; i++) run_cycle();
    set_read(12'hB00); #1 check("cyc_after5", rdata, 32'd5); run_cycle();
    set_read(12'hB80); #1 check("cych_after5", rdata, 32'd0); run_cycle();

    set_csr(12'h340, 2'b00, 3'b001, 32'hDEAD_BEEF, 5'd0); run_cycle();
    set_csr(12'h340, 2'b01, 3'b010, 32'h0000_00FF, 5'd0);
    #1 check("csrrs_old", rdata, 32'hDEAD_BEEF); run_cycle();
    set_read(12'h340); #1 check("mscratch", rdata, 32'hDEAD_BEFF); run_cycle();

    set_csr(12'h300, 2'b11, 3'b110, 32'd0, 5'd8); run_cycle();
    set_csr(12'h300, 2'b11, 3'b111, 32'd0, 5'd8);
    #1 check("csrrci_old_mie", rdata & 32'd8, 32'd8); run_cycle();
    set_read(12'h300); #1 check("mie_cleared", rdata & 32'd8, 32'd0); run_cycle();

    set_csr(12'h300, 2'b11, 3'b110, 32'd0, 5'd8); run_cycle();
    set_csr(12'h305, 2'b00, 3'b001, 32'h0000_0200, 5'd0); run_cycle();
    set_idle(); pc = 32'h100; ecall = 1'b1; retire = 1'b1;
    #1 check("ecall_taken", {31'd0, trap_taken}, 32'd1);
    check("ecall_target", trap_target, 32'h200); run_cycle();
    set_read(12'h341); #1 check("mepc", rdata, 32'h100); run_cycle();
    set_read(12'h342); #1 check("mcause_ecall", rdata, 32'd11); run_cycle();
    set_read(12'h300); #1 check("mstatus_trap", rdata, 32'h0000_1880); run_cycle();
    set_idle(); mret = 1'b1; #1 check("mret_target_dir", mret_target, 32'h100); run_cycle();
    set_read(12'h300); #1 check("mstatus_mret", rdata, 32'h0000_1888); run_cycle();

    set_csr(12'hB00, 2'b00, 3'b001, 32'hFFFF_FFFF, 5'd0); run_cycle();
    set_csr(12'hB80, 2'b00, 3'b001, 32'd0, 5'd0); run_cycle();
    set_idle(); run_cycle();
    set_read(12'hB00); #1 check("cyc_wrap_lo", rdata, 32'd0); run_cycle();
    set_read(12'hB80); #1 check("cyc_wrap_hi", rdata, 32'd1); run_cycle();

    set_csr(12'hC00, 2'b00, 3'b001, 32'd5, 5'd0);
    #1 check("ro_illegal", {31'd0, csr_illegal}, 32'd1);
    check("ro_trap", {31'd0, trap_taken}, 32'd1); run_cycle();
    set_read(12'h342); #1 check("mcause_ill", rdata, 32'd2); run_cycle();
    set_csr(12'h7C0, 2'b01, 3'b010, 32'd0, 5'd0);
    #1 check("unmapped_illegal", {31'd0, csr_illegal}, 32'd1);
    check("unmapped_rdata", rdata, 32'd0); run_cycle();

    for (int i = 0; i < 600; i++) begin
      set_idle();
      csr_addr   = addr_tab[$urandom_range(0, 17)];
      csr_we     = ($urandom_range(0, 1) == 1);
      csr_op     = 2'($urandom_range(0, 3));
      csr_funct3 = 3'($urandom_range(0, 7));
      csr_imm    = 5'($urandom_range(0, 31));
      rs1_data   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) rs1_data = 32'hFFFF_FFFF;
      pc         = $urandom & ~32'd3;
      retire     = ($urandom_range(0, 3) != 0);
      ecall      = ($urandom_range(0, 15) == 0);
      ebreak     = ($urandom_range(0, 15) == 0);
      illegal_in = ($urandom_range(0, 15) == 0);
      mret       = !csr_we && ($urandom_range(0, 7) == 0);
      run_cycle();
      if (i == 300) begin
        reset_check();
        for (int k = 0; k < 3; k++) run_cycle();
        set_read(12'hB00); #1 check("cyc_after_rerst", rdata, 32'd3); run_cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
Machine-mode CSR file for the single-cycle RV32I core, directly downstream of the control unit.
- Consumes csr_addr, csr_write_enable, csr_op, csr_imm and csr_funct3 from the control unit.
- Returns the old CSR value for writeback to rd.
- Holds the 64-bit cycle and instret counters.
- Performs trap entry (ECALL, EBREAK, illegal) and MRET return, supplying redirect targets to the PC logic.

Parameters:
MTVEC_RESET, 32'h0000_0000, reset value of mtvec (direct mode, trap entry address)
HART_ID, 0, value returned by mhartid
MISA_VALUE, 32'h4000_0100, value returned by misa (RV32I)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
csr_addr  in  12  CSR address from control unit
csr_write_enable  in  1  CSR instruction active
csr_op  in  2  00 RW, 01 RS, 10 RC, 11 immediate variant
csr_imm  in  5  zimm for immediate variants
csr_funct3  in  3  funct3 of SYSTEM instruction
rs1_data  in  32  register operand for CSRRW/S/C
pc  in  32  PC of current instruction
instr_retire  in  1  current instruction completes this cycle
trap_ecall  in  1  ECALL decoded
trap_ebreak  in  1  EBREAK decoded
trap_illegal  in  1  illegal instruction (alu_op 4'b1111)
mret  in  1  MRET decoded
csr_rdata  out  32  old value of addressed CSR (combinational)
csr_illegal  out  1  access to unmapped CSR, or write to read-only CSR
trap_taken  out  1  redirect PC to trap_target this cycle
trap_target  out  32  mtvec with bits[1:0] = 0
mret_target  out  32  mepc

Behaviour:
- Reads are combinational and return the pre-write value. Writes, counters and trap state update on posedge clk.
- Operand selection:
  - csr_funct3[2]=1: operand = {27'b0, csr_imm}.
  - Otherwise operand = rs1_data.
- Operation selection:
  - csr_op 00/01/10 decode directly.
  - csr_op 11 decodes from csr_funct3[1:0]: 01 write, 10 set (old|op), 11 clear (old&~op).
- Implemented CSRs (addresses in hex):
  - mstatus 300: MIE bit3 and MPIE bit7 writable; MPP bits[12:11] read 2'b11; other bits read 0.
  - misa 301 and mhartid F14: read-only constants.
  - mtvec 305, mepc 341: bits[1:0] forced 0 on write.
  - mscratch 340, mcause 342: full 32 bits.
  - mcycle B00 / mcycleh B80, minstret B02 / minstreth B82: writable 32-bit halves.
  - cycle C00, cycleh C80, instret C02, instreth C82: read-only aliases.
- csr_illegal:
  - Asserted when csr_write_enable=1 and the address is unmapped; csr_rdata=0.
  - Also asserted on a write-type op to address[11:10]=2'b11, or to misa/mhartid. Set/clear with a zero operand is not a write.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instr_retire & ~trap_taken.
  - A CSR write to either half overrides that cycle's increment for the full 64-bit value; the other half keeps its pre-increment value.
  - Wrap from 2^64-1 to 0 silently.
- Trap:
  - trap_taken = trap_ecall | trap_ebreak | trap_illegal | csr_illegal.
  - On trap: mepc<=pc; mcause<=2 (illegal), else 3 (ebreak), else 11 (ecall), in that priority; MPIE<=MIE; MIE<=0.
  - A CSR write in the trapping cycle is suppressed.
- MRET (when no trap): MIE<=MPIE, MPIE<=1. If trap and mret coincide, the trap wins.
- Reset (asynchronous): all CSRs 0 except mtvec=MTVEC_RESET and MPP=2'b11; counters 0.
  - Outputs during reset: csr_rdata follows inputs with reset state; trap_target=MTVEC_RESET; mret_target=0.
  - Reset deasserted mid-program: counters restart from 0 on the first clk edge after release.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams.
  - mcause codes (2, 3, 11).
  - funct3 op codes.
  - mstatus bit positions.
- Sub-module csr_counter64: 64-bit counter with inc enable and independent low/high write ports; instantiated for mcycle and minstret.

Test Plan:
- Reset release, idle 5 cycles -> read B00 returns 5, B80 returns 0.
- CSRRW 340 with rs1_data=32'hDEADBEEF, then CSRRS 340 with rs1_data=32'h0000_00FF -> second csr_rdata=DEADBEEF, mscratch=DEADBEFF.
- CSRRCI 300 with imm=8 after MIE set -> rdata bit3=1, MIE cleared.
- pc=32'h100, trap_ecall, mtvec=32'h200 -> trap_taken=1, trap_target=200; next cycle mepc=100, mcause=11, MIE=0, MPIE=old MIE; then mret -> mret_target=100, MIE restored.
- Write mcycle=32'hFFFFFFFF, mcycleh=0 -> after 1 idle cycle mcycleh=1, mcycle=0.
- CSRRW to C00, or to address 7C0 -> csr_illegal=1, trap_taken=1, mcause=2, no CSR modified, minstret unchanged.
